// File: rtl/pulse_monitor.sv
// pulse_monitor: passive timing monitor for the pulser outputs.
// Measures each trigger_a repeat window and publishes the period, the three
// pulse widths and the A-to-B delay. It also flags a missing B trigger and a
// stalled sequence.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   trigger_a            laser A trigger; each rise closes/opens a window
//   trigger_b            laser B trigger
//   camera               camera exposure gate
//   period               cycles between the last two trigger_a rises
//   width_a/_b/_cam      high time of the last completed pulse per input
//   delay_ab             window start to first trigger_b rise
//   b_missing            no trigger_b rise in the reported window
//   timeout              sticky; window counter saturated
//   meas_valid           one-cycle strobe, all measurement outputs updated
module pulse_monitor #(
  parameter int unsigned N_BITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger_a,
  input  logic              trigger_b,
  input  logic              camera,
  output logic [N_BITS-1:0] period,
  output logic [N_BITS-1:0] width_a,
  output logic [N_BITS-1:0] width_b,
  output logic [N_BITS-1:0] width_cam,
  output logic [N_BITS-1:0] delay_ab,
  output logic              b_missing,
  output logic              timeout,
  output logic              meas_valid
);

  localparam int unsigned       N_CH    = 3;
  localparam int unsigned       CH_A    = 0;
  localparam int unsigned       CH_B    = 1;
  localparam int unsigned       CH_CAM  = 2;
  localparam logic [N_BITS-1:0] CNT_MAX = '1;
  localparam logic [N_BITS-1:0] CNT_ONE = N_BITS'(1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MEASURE = 1'b1
  } state_e;

  // Edge detection on the raw inputs (same clock domain, no synchronizer).
  logic [N_CH-1:0] in_s;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  assign in_s = {camera, trigger_b, trigger_a};
  assign rise = in_s & ~prev_q;
  assign fall = ~in_s & prev_q;

  // Last completed width per input, independent of window state.
  logic [N_CH-1:0][N_BITS-1:0] pw_last;

  for (genvar g = 0; g < N_CH; g++) begin : g_width
    logic [N_BITS-1:0] cnt_q, cnt_d;
    logic [N_BITS-1:0] last_q, last_d;
    logic              run_q, run_d;

    // A fall only counts if its rise was observed (run_q set).
    always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      run_d  = run_q;
      if (rise[g]) begin
        cnt_d = CNT_ONE;
        run_d = 1'b1;
      end else if (run_q && fall[g]) begin
        last_d = cnt_q;
        run_d  = 1'b0;
      end else if (run_q && in_s[g] && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        last_q <= '0;
        run_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        last_q <= last_d;
        run_q  <= run_d;
      end
    end

    assign pw_last[g] = last_q;
  end

  // Window FSM state and published measurement registers.
  state_e            state_q, state_d;
  logic [N_BITS-1:0] wcnt_q, wcnt_d;
  logic [N_BITS-1:0] dly_q, dly_d;
  logic              b_seen_q, b_seen_d;
  logic [N_BITS-1:0] period_q, period_d;
  logic [N_BITS-1:0] width_a_q, width_a_d;
  logic [N_BITS-1:0] width_b_q, width_b_d;
  logic [N_BITS-1:0] width_cam_q, width_cam_d;
  logic [N_BITS-1:0] delay_ab_q, delay_ab_d;
  logic              b_missing_q, b_missing_d;
  logic              timeout_q, timeout_d;
  logic              meas_valid_q, meas_valid_d;

  // Next-state: open a window on A rise, publish and restart on the next one.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    dly_d        = dly_q;
    b_seen_d     = b_seen_q;
    period_d     = period_q;
    width_a_d    = width_a_q;
    width_b_d    = width_b_q;
    width_cam_d  = width_cam_q;
    delay_ab_d   = delay_ab_q;
    b_missing_d  = b_missing_q;
    timeout_d    = timeout_q;
    meas_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise[CH_A]) begin
          state_d  = S_MEASURE;
          wcnt_d   = CNT_ONE;
          dly_d    = '0;
          b_seen_d = rise[CH_B];
        end
      end

      S_MEASURE: begin
        if (rise[CH_A]) begin
          period_d     = wcnt_q;
          delay_ab_d   = dly_q;
          b_missing_d  = ~b_seen_q;
          width_a_d    = pw_last[CH_A];
          width_b_d    = pw_last[CH_B];
          width_cam_d  = pw_last[CH_CAM];
          timeout_d    = 1'b0;
          meas_valid_d = 1'b1;
          wcnt_d       = CNT_ONE;
          dly_d        = '0;
          // A B rise coincident with the opening A rise counts as delay 0.
          b_seen_d     = rise[CH_B];
        end else begin
          if (rise[CH_B] && !b_seen_q) begin
            dly_d    = wcnt_q;
            b_seen_d = 1'b1;
          end
          if (wcnt_q != CNT_MAX) begin
            wcnt_d = wcnt_q + CNT_ONE;
          end
          // Counter about to saturate: abandon the window without publishing.
          if (wcnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset preloads prev_q to mask a false rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= in_s;
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      dly_q        <= '0;
      b_seen_q     <= 1'b0;
      period_q     <= '0;
      width_a_q    <= '0;
      width_b_q    <= '0;
      width_cam_q  <= '0;
      delay_ab_q   <= '0;
      b_missing_q  <= 1'b0;
      timeout_q    <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      prev_q       <= in_s;
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      dly_q        <= dly_d;
      b_seen_q     <= b_seen_d;
      period_q     <= period_d;
      width_a_q    <= width_a_d;
      width_b_q    <= width_b_d;
      width_cam_q  <= width_cam_d;
      delay_ab_q   <= delay_ab_d;
      b_missing_q  <= b_missing_d;
      timeout_q    <= timeout_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign period     = period_q;
  assign width_a    = width_a_q;
  assign width_b    = width_b_q;
  assign width_cam  = width_cam_q;
  assign delay_ab   = delay_ab_q;
  assign b_missing  = b_missing_q;
  assign timeout    = timeout_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: scoreboard bench for pulse_monitor.
// Instance 0 uses N_BITS=20 for nominal/corner windows and reset mid-window.
// Instance 1 uses N_BITS=8 for the timeout and width saturation cases.
module tb_pulse_monitor;

  localparam int unsigned NB  = 20;
  localparam int unsigned NB8 = 8;

  typedef struct {
    int unsigned p;
    int unsigned wa;
    int unsigned d;
    int unsigned wb;
    int unsigned d2;
    int unsigned wb2;
    int unsigned wc;
  } win_t;

  typedef struct {
    int unsigned period;
    int unsigned wa;
    int unsigned wb;
    int unsigned wc;
    int unsigned dly;
    bit          bmiss;
    bit          tmo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] ta;
  logic [1:0] tb;
  logic [1:0] tc;

  logic [NB-1:0]  per20, wa20, wb20, wc20, dly20;
  logic           bm20, to20, mv20;
  logic [NB8-1:0] per8, wa8, wb8, wc8, dly8;
  logic           bm8, to8, mv8;

  pulse_monitor #(.N_BITS(NB)) u_dut20 (
    .clk       (clk),
    .reset     (rst[0]),
    .trigger_a (ta[0]),
    .trigger_b (tb[0]),
    .camera    (tc[0]),
    .period    (per20),
    .width_a   (wa20),
    .width_b   (wb20),
    .width_cam (wc20),
    .delay_ab  (dly20),
    .b_missing (bm20),
    .timeout   (to20),
    .meas_valid(mv20)
  );

  pulse_monitor #(.N_BITS(NB8)) u_dut8 (
    .clk       (clk),
    .reset     (rst[1]),
    .trigger_a (ta[1]),
    .trigger_b (tb[1]),
    .camera    (tc[1]),
    .period    (per8),
    .width_a   (wa8),
    .width_b   (wb8),
    .width_cam (wc8),
    .delay_ab  (dly8),
    .b_missing (bm8),
    .timeout   (to8),
    .meas_valid(mv8)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t        q20[$];
  exp_t        q8[$];
  exp_t        e20;
  exp_t        e8;
  win_t        ow[2];
  bit          open_w[2];
  int unsigned wb_m[2];
  int unsigned wc_m[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic check_pub(input string who, input exp_t e,
                           input logic [31:0] p, input logic [31:0] wa,
                           input logic [31:0] wb, input logic [31:0] wc,
                           input logic [31:0] dl, input logic bm, input logic tm);
    check({who, " period"},    p,       e.period);
    check({who, " width_a"},   wa,      e.wa);
    check({who, " width_b"},   wb,      e.wb);
    check({who, " width_cam"}, wc,      e.wc);
    check({who, " delay_ab"},  dl,      e.dly);
    check({who, " b_missing"}, 32'(bm), 32'(e.bmiss));
    check({who, " timeout"},   32'(tm), 32'(e.tmo));
  endtask

  // Publish monitors: every meas_valid pops one expected record.
  always @(negedge clk) begin
    if (mv20 === 1'b1) begin
      if (q20.size() == 0) begin
        check("d20 spurious meas_valid", 32'(mv20), 32'd0);
      end else begin
        e20 = q20.pop_front();
        check_pub("d20", e20, 32'(per20), 32'(wa20), 32'(wb20), 32'(wc20),
                  32'(dly20), bm20, to20);
      end
    end
  end

  always @(negedge clk) begin
    if (mv8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("d8 spurious meas_valid", 32'(mv8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check_pub("d8", e8, 32'(per8), 32'(wa8), 32'(wb8), 32'(wc8),
                  32'(dly8), bm8, to8);
      end
    end
  end

  task automatic nxt(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one repeat window; its first cycle closes the previous window.
  task automatic run_win(input int unsigned d, input win_t w);
    exp_t e;
    for (int unsigned c = 0; c < w.p; c++) begin
      ta[d] = (c < w.wa);
      tb[d] = ((w.wb != 0) && (c >= w.d) && (c < w.d + w.wb)) ||
              ((w.wb2 != 0) && (c >= w.d2) && (c < w.d2 + w.wb2));
      tc[d] = (c < w.wc);
      if (c == 0) begin
        if (open_w[d]) begin
          if (ow[d].wb != 0) wb_m[d] = (ow[d].wb2 != 0) ? ow[d].wb2 : ow[d].wb;
          if (ow[d].wc != 0) wc_m[d] = ow[d].wc;
          e.period = ow[d].p;
          e.wa     = ow[d].wa;
          e.wb     = wb_m[d];
          e.wc     = wc_m[d];
          e.dly    = (ow[d].wb != 0) ? ow[d].d : 0;
          e.bmiss  = (ow[d].wb == 0);
          e.tmo    = 1'b0;
          if (d == 0) q20.push_back(e);
          else        q8.push_back(e);
        end
        ow[d]     = w;
        open_w[d] = 1'b1;
      end
      nxt(1);
    end
  endtask

  task automatic check_zero20(input string tag);
    check({tag, " period"},     32'(per20), 32'd0);
    check({tag, " width_a"},    32'(wa20),  32'd0);
    check({tag, " width_b"},    32'(wb20),  32'd0);
    check({tag, " width_cam"},  32'(wc20),  32'd0);
    check({tag, " delay_ab"},   32'(dly20), 32'd0);
    check({tag, " b_missing"},  32'(bm20),  32'd0);
    check({tag, " timeout"},    32'(to20),  32'd0);
    check({tag, " meas_valid"}, 32'(mv20),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t nom;
    nom = '{1000, 10, 30, 10, 0, 0, 20};
    rst = 2'b11;
    ta  = 2'b00;
    tb  = 2'b00;
    tc  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      open_w[i] = 1'b0;
      wb_m[i]   = 0;
      wc_m[i]   = 0;
    end

    nxt(3);
    check_zero20("reset");
    check("d8 reset timeout",    32'(to8), 32'd0);
    check("d8 reset meas_valid", 32'(mv8), 32'd0);
    rst = 2'b00;
    nxt(2);
    check_zero20("post-reset");

    // Nominal, missing B, simultaneous A/B, double B, minimum period.
    repeat (3) run_win(0, nom);
    run_win(0, '{500, 10, 0, 0, 0, 0, 20});
    run_win(0, '{200, 10, 0, 10, 0, 0, 20});
    run_win(0, '{300, 7, 45, 4, 100, 9, 33});
    run_win(0, '{2, 1, 0, 0, 0, 0, 0});
    run_win(0, '{64, 3, 5, 2, 0, 0, 1});

    // Reset at window cycle 500 with trigger_a held high through release.
    run_win(0, '{500, 10, 30, 10, 0, 0, 20});
    rst[0]    = 1'b1;
    ta[0]     = 1'b1;
    tb[0]     = 1'b0;
    tc[0]     = 1'b0;
    open_w[0] = 1'b0;
    wb_m[0]   = 0;
    wc_m[0]   = 0;
    nxt(5);
    check_zero20("mid-reset");
    rst[0] = 1'b0;
    nxt(3);
    ta[0] = 1'b0;
    nxt(10);
    check_zero20("after mid-reset");
    run_win(0, '{100, 4, 12, 6, 0, 0, 0});
    run_win(0, '{150, 6, 20, 3, 0, 0, 8});
    run_win(0, '{20, 2, 0, 0, 0, 0, 0});

    // N_BITS=8: single rise, then stall until timeout.
    ta[1] = 1'b1;
    nxt(1);
    for (int k = 1; k <= 260; k++) begin
      if (k == 3) ta[1] = 1'b0;
      nxt(1);
      if (k == 253) check("d8 timeout before 254", 32'(to8), 32'd0);
      if (k == 254) check("d8 timeout at 254",     32'(to8), 32'd1);
    end
    check("d8 timeout sticky", 32'(to8), 32'd1);
    run_win(1, '{50, 3, 0, 0, 0, 0, 0});
    run_win(1, '{50, 3, 0, 0, 0, 0, 0});

    // N_BITS=8: camera held 400 cycles saturates its width counter.
    tc[1] = 1'b1;
    nxt(400);
    tc[1] = 1'b0;
    nxt(5);
    open_w[1] = 1'b0;
    wc_m[1]   = 255;
    check("d8 timeout after stall", 32'(to8), 32'd1);
    run_win(1, '{20, 2, 0, 0, 0, 0, 0});
    run_win(1, '{20, 2, 0, 0, 0, 0, 0});

    nxt(5);
    check("d20 scoreboard drained", 32'(q20.size()), 32'd0);
    check("d8 scoreboard drained",  32'(q8.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
